qeip_apb_initiator: RTL and testbench



---
 rtl/qeip_pkg.sv | 42 ++++
 rtl/apb_xfer_engine.sv | 118 +++++++++++
 rtl/qeip_apb_initiator.sv | 216 +++++++++++++++++++++
 tb/tb_qeip_apb_initiator.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qeip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qeip_pkg
// Description : Definitions shared by the Grover QEIP APB responder and its
//               APB initiator: register offsets, result status codes and the
//               control / transfer state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package qeip_pkg;

    // Register map, relative to the QEIP base address
    localparam int unsigned FUNC_TABLE_OFS = 32'h0000_0000;
    localparam int unsigned ACTIVATE_OFS   = 32'h0000_0100;

    // Command result status
    typedef enum logic [1:0] {
        RES_HIT     = 2'd0,
        RES_MISS    = 2'd1,
        RES_SLVERR  = 2'd2,
        RES_TIMEOUT = 2'd3
    } res_status_t;

    // Command-level control FSM
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_SETUP  = 3'd1,
        ST_WR_ACCESS = 3'd2,
        ST_RD_SETUP  = 3'd3,
        ST_RD_ACCESS = 3'd4,
        ST_CHECK     = 3'd5,
        ST_DONE      = 3'd6
    } ctrl_state_t;

    // Single-transfer APB phase sequencer
    typedef enum logic [1:0] {
        XF_IDLE   = 2'd0,
        XF_SETUP  = 2'd1,
        XF_ACCESS = 2'd2
    } xfer_state_t;

endpackage
`default_nettype wire

// File: rtl/apb_xfer_engine.sv
`default_nettype none
// ============================================================================
// Module      : apb_xfer_engine
// Description : Runs one APB transfer (SETUP then ACCESS) per request, with a
//               wait-state timeout. All APB outputs come straight from flops.
// Revision    : 1.0 - initial release
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req                 start a transfer; sampled in idle or on the cycle the
//                       current ACCESS completes (back-to-back via new SETUP)
//   req_addr/write/wdata transfer attributes, latched when req is taken
//   ack                 ACCESS completing this cycle (spready high)
//   ack_err             spslverr qualifying ack
//   ack_timeout         wait-state budget exhausted this cycle; bus released
//   sp*                 APB requester signals
// ============================================================================
module apb_xfer_engine
    import qeip_pkg::*;
#(
    parameter int BW_DATA = 32,
    parameter int BW_ADDR = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic [BW_ADDR-1:0] req_addr,
    input  logic               req_write,
    input  logic [BW_DATA-1:0] req_wdata,
    output logic               ack,
    output logic               ack_err,
    output logic               ack_timeout,
    output logic               spsel,
    output logic               spenable,
    output logic [BW_ADDR-1:0] spaddr,
    output logic               spwrite,
    output logic [BW_DATA-1:0] spwdata,
    input  logic               spready,
    input  logic               spslverr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    xfer_state_t      r_state;
    xfer_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_load;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        ack         = 1'b0;
        ack_err     = 1'b0;
        ack_timeout = 1'b0;
        case (r_state)
            XF_IDLE: begin
                if (req) begin
                    w_state_nxt = XF_SETUP;
                    w_load      = 1'b1;
                end
            end
            XF_SETUP: begin
                w_state_nxt = XF_ACCESS;
            end
            XF_ACCESS: begin
                if (spready) begin
                    ack     = 1'b1;
                    ack_err = spslverr;
                    // A follow-on request goes through its own SETUP phase
                    if (req) begin
                        w_state_nxt = XF_SETUP;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = XF_IDLE;
                    end
                end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th unready ACCESS cycle
                    ack_timeout = 1'b1;
                    w_state_nxt = XF_IDLE;
                end
            end
            default: begin
                w_state_nxt = XF_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= XF_IDLE;
            r_wait_cnt <= '0;
            spsel      <= 1'b0;
            spenable   <= 1'b0;
            spaddr     <= '0;
            spwrite    <= 1'b0;
            spwdata    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            spsel    <= (w_state_nxt != XF_IDLE);
            spenable <= (w_state_nxt == XF_ACCESS);
            // Attributes only change on entry to SETUP, so they stay stable
            // through the completing ACCESS cycle.
            if (w_load) begin
                spaddr  <= req_addr;
                spwrite <= req_write;
                spwdata <= req_wdata;
            end
            if (w_state_nxt == XF_SETUP) begin
                r_wait_cnt <= '0;
            end else if (r_state == XF_ACCESS && !spready) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/qeip_apb_initiator.sv
`default_nettype none
// ============================================================================
// Module      : qeip_apb_initiator
// Description : APB requester for the Grover QEIP. Per command it writes the
//               target into the function table, then reads the activate
//               register (stalls until a measurement exists), and repeats the
//               pair until the measurement matches or the trial budget ends.
// Revision    : 1.0 - initial release
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/ready/target   command port; ready only while idle
//   res_valid                one-cycle result strobe
//   res_index                last measured value, raw sprdata[NUM_QUBIT:0]
//   res_status               0 hit, 1 miss, 2 slave error, 3 timeout
//   res_trials               write/read trials consumed
//   sp*                      APB requester interface to the QEIP
// ============================================================================
module qeip_apb_initiator
    import qeip_pkg::*;
#(
    parameter int                 BW_DATA   = 32,
    parameter int                 BW_ADDR   = 32,
    parameter int                 NUM_QUBIT = 4,
    parameter logic [BW_ADDR-1:0] BASE_ADDR = '0,
    parameter int                 MAX_TRIAL = 4,
    parameter int                 TIMEOUT   = 1024,
    localparam int                TRIAL_W   = $clog2(MAX_TRIAL + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [NUM_QUBIT-1:0] cmd_target,
    output logic                 res_valid,
    output logic [NUM_QUBIT:0]   res_index,
    output logic [1:0]           res_status,
    output logic [TRIAL_W-1:0]   res_trials,
    output logic                 spsel,
    output logic                 spenable,
    output logic [BW_ADDR-1:0]   spaddr,
    output logic                 spwrite,
    output logic [BW_DATA-1:0]   spwdata,
    input  logic [BW_DATA-1:0]   sprdata,
    input  logic                 spready,
    input  logic                 spslverr
);

    localparam logic [BW_ADDR-1:0] c_func_addr = BASE_ADDR + BW_ADDR'(FUNC_TABLE_OFS);
    localparam logic [BW_ADDR-1:0] c_act_addr  = BASE_ADDR + BW_ADDR'(ACTIVATE_OFS);

    ctrl_state_t          r_state;
    ctrl_state_t          w_state_nxt;
    logic [NUM_QUBIT-1:0] r_target;
    logic [NUM_QUBIT:0]   r_meas;
    logic [NUM_QUBIT:0]   w_meas_nxt;
    logic [TRIAL_W-1:0]   r_trials;
    logic [TRIAL_W-1:0]   w_trials_nxt;
    res_status_t          w_done_status;
    logic                 w_enter_done;
    logic                 w_latch_target;
    logic                 w_hit;

    logic                 w_req;
    logic                 w_req_write;
    logic [BW_ADDR-1:0]   w_req_addr;
    logic [BW_DATA-1:0]   w_req_wdata;
    logic                 w_ack;
    logic                 w_ack_err;
    logic                 w_ack_timeout;

    // Only the measurement field of the read data is meaningful
    logic                 w_unused_rdata;
    assign w_unused_rdata = ^sprdata[BW_DATA-1:NUM_QUBIT+1];

    assign cmd_ready = (r_state == ST_IDLE);

    // The target is not yet latched on the accepting cycle, so the first
    // write takes it straight from the command port.
    assign w_req_wdata = (r_state == ST_IDLE) ? BW_DATA'(cmd_target) : BW_DATA'(r_target);

    // Bit NUM_QUBIT flags an invalid measurement and never counts as a hit
    assign w_hit = !r_meas[NUM_QUBIT] && (r_meas[NUM_QUBIT-1:0] == r_target);

    always_comb begin
        w_state_nxt    = r_state;
        w_req          = 1'b0;
        w_req_write    = 1'b1;
        w_req_addr     = c_func_addr;
        w_latch_target = 1'b0;
        w_trials_nxt   = r_trials;
        w_meas_nxt     = r_meas;
        w_done_status  = RES_HIT;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_req          = 1'b1;
                    w_latch_target = 1'b1;
                    w_trials_nxt   = TRIAL_W'(1);
                    w_state_nxt    = ST_WR_SETUP;
                end
            end
            ST_WR_SETUP: begin
                w_state_nxt = ST_WR_ACCESS;
            end
            ST_WR_ACCESS: begin
                if (w_ack) begin
                    if (w_ack_err) begin
                        w_done_status = RES_SLVERR;
                        w_state_nxt   = ST_DONE;
                    end else begin
                        w_req       = 1'b1;
                        w_req_write = 1'b0;
                        w_req_addr  = c_act_addr;
                        w_state_nxt = ST_RD_SETUP;
                    end
                end else if (w_ack_timeout) begin
                    w_done_status = RES_TIMEOUT;
                    w_state_nxt   = ST_DONE;
                end
            end
            ST_RD_SETUP: begin
                w_state_nxt = ST_RD_ACCESS;
            end
            ST_RD_ACCESS: begin
                if (w_ack) begin
                    w_meas_nxt = sprdata[NUM_QUBIT:0];
                    if (w_ack_err) begin
                        w_done_status = RES_SLVERR;
                        w_state_nxt   = ST_DONE;
                    end else begin
                        w_state_nxt = ST_CHECK;
                    end
                end else if (w_ack_timeout) begin
                    w_done_status = RES_TIMEOUT;
                    w_state_nxt   = ST_DONE;
                end
            end
            ST_CHECK: begin
                if (w_hit) begin
                    w_done_status = RES_HIT;
                    w_state_nxt   = ST_DONE;
                end else if (r_trials == TRIAL_W'(MAX_TRIAL)) begin
                    w_done_status = RES_MISS;
                    w_state_nxt   = ST_DONE;
                end else begin
                    // Rewrite the function table before every trial
                    w_trials_nxt = r_trials + TRIAL_W'(1);
                    w_req        = 1'b1;
                    w_state_nxt  = ST_WR_SETUP;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // DONE always returns to IDLE, so any transition into DONE is an entry
    assign w_enter_done = (w_state_nxt == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_target   <= '0;
            r_meas     <= '0;
            r_trials   <= '0;
            res_valid  <= 1'b0;
            res_index  <= '0;
            res_status <= '0;
            res_trials <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_meas    <= w_meas_nxt;
            r_trials  <= w_trials_nxt;
            res_valid <= w_enter_done;
            if (w_latch_target) begin
                r_target <= cmd_target;
            end
            // Result registers only move when a command finishes
            if (w_enter_done) begin
                res_index  <= w_meas_nxt;
                res_status <= w_done_status;
                res_trials <= r_trials;
            end
        end
    end

    apb_xfer_engine #(
        .BW_DATA (BW_DATA),
        .BW_ADDR (BW_ADDR),
        .TIMEOUT (TIMEOUT)
    ) u_xfer (
        .clk         (clk),
        .rst         (rst),
        .req         (w_req),
        .req_addr    (w_req_addr),
        .req_write   (w_req_write),
        .req_wdata   (w_req_wdata),
        .ack         (w_ack),
        .ack_err     (w_ack_err),
        .ack_timeout (w_ack_timeout),
        .spsel       (spsel),
        .spenable    (spenable),
        .spaddr      (spaddr),
        .spwrite     (spwrite),
        .spwdata     (spwdata),
        .spready     (spready),
        .spslverr    (spslverr)
    );

endmodule
`default_nettype wire

// File: tb/tb_qeip_apb_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_qeip_apb_initiator
// Description : Directed bench for qeip_apb_initiator. A scripted APB
//               responder answers each transfer; expected transfers and
//               results are queued by the stimulus and popped by monitors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qeip_apb_initiator;
    import qeip_pkg::*;

    localparam int NQ = 4;
    localparam int MT = 4;
    localparam int TO = 8;
    localparam int TW = $clog2(MT + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [NQ-1:0] cmd_target;
    logic          res_valid;
    logic [NQ:0]   res_index;
    logic [1:0]    res_status;
    logic [TW-1:0] res_trials;
    logic          spsel;
    logic          spenable;
    logic [31:0]   spaddr;
    logic          spwrite;
    logic [31:0]   spwdata;
    logic [31:0]   sprdata;
    logic          spready;
    logic          spslverr;

    always #5 clk = ~clk;

    qeip_apb_initiator #(
        .BW_DATA   (32),
        .BW_ADDR   (32),
        .NUM_QUBIT (NQ),
        .BASE_ADDR (32'h0),
        .MAX_TRIAL (MT),
        .TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .res_valid  (res_valid),
        .res_index  (res_index),
        .res_status (res_status),
        .res_trials (res_trials),
        .spsel      (spsel),
        .spenable   (spenable),
        .spaddr     (spaddr),
        .spwrite    (spwrite),
        .spwdata    (spwdata),
        .sprdata    (sprdata),
        .spready    (spready),
        .spslverr   (spslverr)
    );

    typedef struct { bit wr; logic [31:0] addr; logic [31:0] wdata; } xfer_t;
    typedef struct { int ws; logic [31:0] rdata; bit err; } resp_t;
    typedef struct { logic [1:0] st; logic [TW-1:0] trials; logic [NQ:0] idx; int lat; } res_t;

    xfer_t exp_xq[$];
    resp_t resp_q[$];
    res_t  exp_rq[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;
    int last_acc_len = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- APB monitor + scripted responder ----------------
    initial begin : apb_side
        resp_t       cur;
        xfer_t       e;
        bit          in_acc;
        bit          prev_done;
        int          wcnt;
        int          run;
        logic [31:0] s_addr;
        logic [31:0] s_wdata;
        logic        s_wr;
        in_acc = 0; prev_done = 0; wcnt = 0; run = 0;
        s_addr = '0; s_wdata = '0; s_wr = 1'b0;
        cur = '{0, 32'h0, 1'b0};
        forever begin
            @(negedge clk);
            if (rst) begin
                in_acc = 0; run = 0; prev_done = 0;
                spready = 1'b0; spslverr = 1'b0; sprdata = 32'hFFFF_FFFF;
                continue;
            end
            if (spenable) chk("penable_without_psel", spsel, 1);
            if (spsel && !spenable) begin
                if (exp_xq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_xfer: got addr 0x%0h write %0d, none required", spaddr, spwrite);
                end else begin
                    e = exp_xq.pop_front();
                    chk("xfer_write", spwrite, e.wr);
                    chk("xfer_addr", spaddr, e.addr);
                    if (e.wr) chk("xfer_wdata", spwdata, e.wdata);
                end
                s_addr = spaddr; s_wr = spwrite; s_wdata = spwdata;
            end
            if (spsel && spenable) begin
                chk("access_after_access", prev_done, 0);
                chk("stable_addr", spaddr, s_addr);
                chk("stable_write", spwrite, s_wr);
                chk("stable_wdata", spwdata, s_wdata);
            end
            prev_done = 0;
            if (spsel && spenable) begin
                if (!in_acc) begin
                    in_acc = 1; wcnt = 0;
                    if (resp_q.size() != 0) cur = resp_q.pop_front();
                    else cur = '{0, 32'h0, 1'b0};
                end
                run++;
                if (wcnt < cur.ws) begin
                    wcnt++;
                    spready = 1'b0; spslverr = 1'b0; sprdata = 32'hFFFF_FFFF;
                end else begin
                    spready = 1'b1; spslverr = cur.err; sprdata = cur.rdata;
                    in_acc = 0; prev_done = 1;
                end
            end else begin
                in_acc = 0;
                spready = 1'b0; spslverr = 1'b0; sprdata = 32'hFFFF_FFFF;
                if (run > 0) last_acc_len = run;
                run = 0;
            end
        end
    end

    // ---------------- result monitor ----------------
    initial begin : res_side
        res_t r;
        forever begin
            @(negedge clk);
            if (!rst && res_valid) begin
                if (exp_rq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_result: got status %0d, none required", res_status);
                end else begin
                    r = exp_rq.pop_front();
                    chk("res_status", res_status, r.st);
                    chk("res_trials", res_trials, r.trials);
                    chk("res_index", res_index, r.idx);
                    if (r.lat >= 0) chk("res_latency", cyc - t0, r.lat);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_write(input logic [NQ-1:0] tgt, input bit err);
        exp_xq.push_back('{1'b1, 32'h0000_0000, 32'(tgt)});
        resp_q.push_back('{0, 32'h0, err});
    endtask

    task automatic push_read(input int ws, input logic [31:0] rd, input bit err);
        exp_xq.push_back('{1'b0, 32'h0000_0100, 32'h0});
        resp_q.push_back('{ws, rd, err});
    endtask

    task automatic trial(input logic [NQ-1:0] tgt, input int ws, input logic [31:0] rd);
        push_write(tgt, 1'b0);
        push_read(ws, rd, 1'b0);
    endtask

    // Called at a negedge; returns at the negedge after acceptance
    task automatic issue(input logic [NQ-1:0] tgt);
        int k;
        k = 0;
        while (!cmd_ready && k < 300) begin @(negedge clk); k++; end
        chk("cmd_ready_before_issue", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_target = tgt; t0 = cyc;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_target = ~tgt;
    endtask

    task automatic wait_res(input string name);
        int k;
        k = 0;
        while (!res_valid && k < 300) begin @(negedge clk); k++; end
        if (!res_valid) begin
            n_chk++; n_fail++;
            $display("FAIL %s_no_result: got no res_valid, required one within 300 cycles", name);
        end else begin
            @(negedge clk);
            chk({name, "_pulse_one_cycle"}, res_valid, 0);
            chk({name, "_ready_after_done"}, cmd_ready, 1);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no end of test, required finish before time 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int k;
        rst = 1'b1; cmd_valid = 1'b0; cmd_target = '0;
        spready = 1'b0; spslverr = 1'b0; sprdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_spsel", spsel, 0);
        chk("rst_spenable", spenable, 0);
        chk("rst_spwrite", spwrite, 0);
        chk("rst_spaddr", spaddr, 0);
        chk("rst_spwdata", spwdata, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_index", res_index, 0);
        chk("rst_res_status", res_status, 0);
        chk("rst_res_trials", res_trials, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: first-trial hit, 3 read wait states
        trial(4'd5, 3, 32'h0000_0005);
        exp_rq.push_back('{2'd0, TW'(1), 5'h05, 9});
        issue(4'd5);
        wait_res("t1_hit");

        // 2: four misses; a command offered while busy must be ignored
        for (int i = 0; i < 4; i++) trial(4'd5, 0, 32'h0000_0003);
        exp_rq.push_back('{2'd1, TW'(4), 5'h03, 21});
        issue(4'd5);
        cmd_valid = 1'b1; cmd_target = 4'hF;
        repeat (5) begin
            chk("t2_busy_not_ready", cmd_ready, 0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        wait_res("t2_miss");

        // 3: miss then hit; upper read-data bits ignored
        trial(4'd5, 1, 32'h0000_0009);
        trial(4'd5, 0, 32'hABCD_0005);
        exp_rq.push_back('{2'd0, TW'(2), 5'h05, -1});
        issue(4'd5);
        wait_res("t3_second_hit");

        // 4: invalid-flag measurement 0x10 never hits target 0
        for (int i = 0; i < 4; i++) trial(4'd0, 0, 32'h0000_0010);
        exp_rq.push_back('{2'd1, TW'(4), 5'h10, -1});
        issue(4'd0);
        wait_res("t4_flag_miss");

        // 5: slave error on write; no read follows
        push_write(4'd6, 1'b1);
        exp_rq.push_back('{2'd2, TW'(1), 5'h10, 3});
        issue(4'd6);
        wait_res("t5_wr_slverr");

        // 6: slave error on read; data still captured
        push_write(4'd7, 1'b0);
        push_read(2, 32'h0000_0007, 1'b1);
        exp_rq.push_back('{2'd2, TW'(1), 5'h07, -1});
        issue(4'd7);
        wait_res("t6_rd_slverr");

        // 7: read never ready -> timeout after TO access cycles
        push_write(4'd9, 1'b0);
        push_read(1000, 32'h0, 1'b0);
        exp_rq.push_back('{2'd3, TW'(1), 5'h07, 12});
        issue(4'd9);
        wait_res("t7_timeout");
        chk("t7_access_cycles", last_acc_len, TO);

        // 8: reset during read access
        push_write(4'd3, 1'b0);
        push_read(1000, 32'h0, 1'b0);
        issue(4'd3);
        k = 0;
        while (!(spsel && spenable && !spwrite) && k < 50) begin @(negedge clk); k++; end
        chk("t8_reached_rd_access", spsel && spenable && !spwrite, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t8_rst_spsel", spsel, 0);
        chk("t8_rst_spenable", spenable, 0);
        chk("t8_rst_res_valid", res_valid, 0);
        chk("t8_rst_cmd_ready", cmd_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // 9: normal command after the reset
        trial(4'hA, 2, 32'h0000_000A);
        exp_rq.push_back('{2'd0, TW'(1), 5'h0A, 8});
        issue(4'hA);
        wait_res("t9_after_rst");

        repeat (3) @(negedge clk);
        chk("left_xfers", exp_xq.size(), 0);
        chk("left_responses", resp_q.size(), 0);
        chk("left_results", exp_rq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
